// File: rtl/chain_tail.sv
// chain_tail: terminal sink of the snode chain; RDC event FIFO plus sticky status and pulses.
package chain_pkg;
  typedef enum logic [2:0] {DEL = 3'd0, ADD = 3'd1, SET = 3'd2, RDC = 3'd3, MSC = 3'd4} opc_e;
endpackage

module chain_tail
  import chain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bgn_in,
  output logic          fns_out,
  input  logic [2:0]    opc_in,
  input  logic          mode_in,
  input  logic [27:0]   id_in,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic          evt_mode,
  output logic [27:0]   evt_id,
  output logic          conflict,
  output logic          chain_full,
  output logic          err,
  output logic          sweep_done,
  output logic          del_ack,
  output logic [CW-1:0] set_cnt,
  input  logic          clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [28:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          r_rdy, r_fns, r_conf, r_full, r_err, r_sweep, r_del;
  logic [CW-1:0] r_set;
  logic          w_push, w_pop, w_msc;
  assign w_push     = r_fns && opc_in == RDC;
  assign w_pop      = r_cnt != '0 && evt_ready;
  assign w_msc      = r_fns && opc_in == MSC;
  assign fns_out    = r_fns;
  assign evt_valid  = r_cnt != '0;
  assign {evt_mode, evt_id} = evt_valid ? r_mem[r_rd] : '0;
  assign conflict   = r_conf;
  assign chain_full = r_full;
  assign err        = r_err;
  assign sweep_done = r_sweep;
  assign del_ack    = r_del;
  assign set_cnt    = r_set;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {mode_in, id_in};
  // r_rdy holds off the first handshake until one full edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy   <= 1'b0;
      r_fns   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_conf  <= 1'b0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_sweep <= 1'b0;
      r_del   <= 1'b0;
      r_set   <= '0;
    end else begin
      r_rdy   <= 1'b1;
      r_fns   <= r_rdy && bgn_in && !r_fns && r_cnt < FULL;
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_cnt   <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_conf  <= (r_conf && !clr) || (w_push && !mode_in);
      r_full  <= (r_full && !clr) || (r_fns && opc_in == ADD) || (w_msc && id_in == 28'd0);
      r_err   <= (r_err && !clr) || (r_fns && opc_in > MSC) || (w_msc && id_in == 28'd2);
      r_sweep <= w_msc && id_in == 28'd1;
      r_del   <= r_fns && opc_in == DEL;
      r_set   <= (clr ? '0 : r_set) + CW'(r_fns && opc_in == SET);
    end
  end
endmodule

// File: tb/tb_chain_tail.sv
// tb_chain_tail: scenario tasks plus random traffic checked against a queue-based model.
module tb_chain_tail;
  import chain_pkg::*;
  logic        clk = 0, rst_n = 0, bgn_in = 0, evt_ready = 0, clr = 0, mode_in = 0;
  logic [2:0]  opc_in = 0;
  logic [27:0] id_in = 0;
  logic        fns_out, evt_valid, evt_mode, conflict, chain_full, err, sweep_done, del_ack;
  logic [27:0] evt_id;
  logic [3:0]  set_cnt;
  int          errors = 0, checks = 0, waited;
  logic [28:0] q[$];
  logic [28:0] h;
  bit          m_conf, m_full, m_err;
  int          m_cnt;

  chain_tail #(.DEPTH(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bgn_in(bgn_in), .fns_out(fns_out), .opc_in(opc_in),
    .mode_in(mode_in), .id_in(id_in), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_mode(evt_mode), .evt_id(evt_id), .conflict(conflict), .chain_full(chain_full),
    .err(err), .sweep_done(sweep_done), .del_ack(del_ack), .set_cnt(set_cnt), .clr(clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_conf = 0; m_full = 0; m_err = 0; m_cnt = 0;
  endtask

  // Offer one message like an snode sender; returns at the negedge after the consume edge
  task automatic send(input int opc, input bit mode, input int id, input bit c, input bit p);
    opc_in = 3'(opc); mode_in = mode; id_in = 28'(id); bgn_in = 1; waited = 0;
    do begin @(negedge clk); waited++; end while (!fns_out && waited < 20);
    checks++;
    if (!fns_out) begin errors++; $display("FAIL handshake_timeout: fns_out=%b required=1 opc=%0d", fns_out, opc); end
    bgn_in = 0; clr = c; evt_ready = p;
    if (fns_out) begin
      if (p && q.size() > 0) void'(q.pop_front());
      if (opc == 3) q.push_back({mode, 28'(id)});
      m_conf = (m_conf && !c) || (opc == 3 && !mode);
      m_full = (m_full && !c) || opc == 1 || (opc == 4 && id == 0);
      m_err  = (m_err && !c) || opc > 4 || (opc == 4 && id == 2);
      m_cnt  = c ? int'(opc == 2) : (m_cnt + int'(opc == 2)) % 16;
    end
    @(negedge clk); clr = 0; evt_ready = 0;
  endtask

  task automatic pop();
    evt_ready = 1; @(negedge clk); evt_ready = 0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 0; #3;
    checks++;
    if ({fns_out, evt_valid, evt_mode, evt_id} !== '0) begin errors++; $display("FAIL reset_handshake_fifo: got %b/%b/%b/%h required all 0", fns_out, evt_valid, evt_mode, evt_id); end
    checks++;
    if ({conflict, chain_full, err, sweep_done, del_ack, set_cnt} !== '0) begin errors++; $display("FAIL reset_flags: got %b%b%b%b%b cnt=%0d required all 0", conflict, chain_full, err, sweep_done, del_ack, set_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1; model_reset();
    @(negedge clk);
  endtask

  task automatic test_rdc_unit();
    send(3, 1, 'h0000123, 0, 0);
    checks++;
    if (waited !== 1) begin errors++; $display("FAIL rdc_latency: fns after %0d cycles required 1", waited); end
    checks++;
    if (fns_out !== 1'b0) begin errors++; $display("FAIL fns_width: fns_out=%b required 0", fns_out); end
    checks++;
    if ({evt_valid, evt_mode, evt_id, conflict} !== {1'b1, 1'b1, 28'h123, 1'b0}) begin errors++; $display("FAIL rdc_head: valid=%b mode=%b id=%h conflict=%b required 1 1 123 0", evt_valid, evt_mode, evt_id, conflict); end
    pop();
    checks++;
    if (evt_valid !== 1'b0 || evt_id !== 28'h0) begin errors++; $display("FAIL rdc_pop: valid=%b id=%h required 0 0", evt_valid, evt_id); end
  endtask

  task automatic test_fifo_full();
    int seen;
    for (int i = 10; i < 14; i++) send(3, 0, i, 0, 0);
    opc_in = 3'(RDC); mode_in = 0; id_in = 28'd14; bgn_in = 1; seen = 0;
    repeat (5) begin @(negedge clk); seen += int'(fns_out); end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL full_stall: fns pulses=%0d required 0", seen); end
    checks++;
    if (conflict !== 1'b1 || evt_id !== 28'd10) begin errors++; $display("FAIL full_state: conflict=%b head=%0d required 1 10", conflict, evt_id); end
    evt_ready = 1; @(negedge clk); evt_ready = 0; void'(q.pop_front());
    checks++;
    if (fns_out !== 1'b0) begin errors++; $display("FAIL full_pop_edge: fns_out=%b required 0", fns_out); end
    @(negedge clk);
    checks++;
    if (fns_out !== 1'b1) begin errors++; $display("FAIL full_resume: fns_out=%b required 1", fns_out); end
    bgn_in = 0; q.push_back({1'b0, 28'd14});
    @(negedge clk);
    for (int i = 11; i <= 14; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 28'(i) || evt_mode !== 1'b0) begin errors++; $display("FAIL drain_order: valid=%b id=%0d mode=%b required 1 %0d 0", evt_valid, evt_id, evt_mode, i); end
      pop();
    end
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: valid=%b required 0", evt_valid); end
  endtask

  task automatic test_markers();
    send(4, 0, 1, 0, 0);
    checks++;
    if (sweep_done !== 1'b1) begin errors++; $display("FAIL sweep_pulse: sweep_done=%b required 1", sweep_done); end
    @(negedge clk);
    checks++;
    if (sweep_done !== 1'b0) begin errors++; $display("FAIL sweep_width: sweep_done=%b required 0", sweep_done); end
    send(4, 0, 0, 0, 0);
    checks++;
    if (chain_full !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL msc_fll: chain_full=%b err=%b required 1 0", chain_full, err); end
    send(4, 0, 2, 0, 0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL msc_err: err=%b required 1", err); end
    send(0, 0, 7, 0, 0);
    checks++;
    if (del_ack !== 1'b1 || sweep_done !== 1'b0) begin errors++; $display("FAIL del_ack: del_ack=%b sweep=%b required 1 0", del_ack, sweep_done); end
    clr = 1; @(negedge clk); clr = 0;
    m_conf = 0; m_full = 0; m_err = 0; m_cnt = 0;
    checks++;
    if ({conflict, chain_full, err, del_ack} !== 4'b0) begin errors++; $display("FAIL clr_flags: conflict=%b full=%b err=%b del=%b required 0", conflict, chain_full, err, del_ack); end
  endtask

  task automatic test_set_wrap();
    for (int k = 1; k <= 17; k++) begin
      send(2, 0, 0, 0, 0);
      checks++;
      if (set_cnt !== 4'(k % 16)) begin errors++; $display("FAIL set_wrap_%0d: set_cnt=%0d required %0d", k, set_cnt, k % 16); end
    end
    send(2, 0, 0, 1, 0);
    checks++;
    if (set_cnt !== 4'd1) begin errors++; $display("FAIL set_clr: set_cnt=%0d required 1", set_cnt); end
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 3; i++) send(3, 1, 32'($urandom) & 'hFFFFFFF, 0, 0);
    send(3, 0, 'h0ABCDEF, 0, 1);
    send(3, 1, 'h0000042, 0, 0);
    checks++;
    if (waited !== 1) begin errors++; $display("FAIL push_pop_nostall: fns after %0d cycles required 1", waited); end
    while (q.size() > 0) begin
      h = q[0];
      checks++;
      if ({evt_valid, evt_mode, evt_id} !== {1'b1, h}) begin errors++; $display("FAIL push_pop_order: valid=%b mode=%b id=%h required 1 %b %h", evt_valid, evt_mode, evt_id, h[28], h[27:0]); end
      pop();
    end
  endtask

  task automatic test_random();
    int opc, id;
    bit pls;
    for (int n = 0; n < 80; n++) begin
      if (q.size() == 4 || $urandom_range(0, 2) == 0) begin
        pop();
        h = q.size() > 0 ? q[0] : '0;
        checks++;
        if ({evt_valid, evt_mode, evt_id} !== {q.size() > 0, h}) begin errors++; $display("FAIL rand_pop_%0d: valid=%b mode=%b id=%h required %b %b %h", n, evt_valid, evt_mode, evt_id, q.size() > 0, h[28], h[27:0]); end
      end
      opc = $urandom_range(0, 7);
      id  = opc == 4 ? $urandom_range(0, 3) : 32'($urandom) & 'hFFFFFFF;
      pls = opc == 4 && id == 1;
      send(opc, 1'($urandom), id, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
      h = q.size() > 0 ? q[0] : '0;
      checks++;
      if ({conflict, chain_full, err, set_cnt} !== {m_conf, m_full, m_err, 4'(m_cnt)}) begin errors++; $display("FAIL rand_flags_%0d: c=%b f=%b e=%b cnt=%0d required %b %b %b %0d", n, conflict, chain_full, err, set_cnt, m_conf, m_full, m_err, m_cnt); end
      checks++;
      if ({evt_valid, evt_mode, evt_id} !== {q.size() > 0, h}) begin errors++; $display("FAIL rand_head_%0d: valid=%b mode=%b id=%h required %b %b %h", n, evt_valid, evt_mode, evt_id, q.size() > 0, h[28], h[27:0]); end
      checks++;
      if ({sweep_done, del_ack} !== {pls, opc == 0}) begin errors++; $display("FAIL rand_pulse_%0d: sweep=%b del=%b required %b %b", n, sweep_done, del_ack, pls, opc == 0); end
    end
  endtask

  task automatic test_async_reset();
    while (q.size() > 0) pop();
    send(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) send(3, 0, i + 100, 0, 0);
    opc_in = 3'(RDC); mode_in = 0; id_in = 28'd200; bgn_in = 1; waited = 0;
    do begin @(negedge clk); waited++; end while (!fns_out && waited < 20);
    checks++;
    if (fns_out !== 1'b1 || evt_valid !== 1'b1) begin errors++; $display("FAIL areset_setup: fns=%b valid=%b required 1 1", fns_out, evt_valid); end
    #2 rst_n = 0; #1;
    checks++;
    if ({fns_out, evt_valid, evt_id} !== '0) begin errors++; $display("FAIL areset_immediate: fns=%b valid=%b id=%h required 0", fns_out, evt_valid, evt_id); end
    checks++;
    if ({conflict, chain_full, err, set_cnt} !== '0) begin errors++; $display("FAIL areset_flags: c=%b f=%b e=%b cnt=%0d required 0", conflict, chain_full, err, set_cnt); end
    @(negedge clk); rst_n = 1; model_reset();
    @(negedge clk);
    checks++;
    if (fns_out !== 1'b0) begin errors++; $display("FAIL areset_early_fns: fns=%b required 0 after first edge", fns_out); end
    @(negedge clk);
    checks++;
    if (fns_out !== 1'b1) begin errors++; $display("FAIL areset_rehandshake: fns=%b required 1 after second edge", fns_out); end
    bgn_in = 0;
    @(negedge clk);
    checks++;
    if ({evt_valid, evt_id, conflict} !== {1'b1, 28'd200, 1'b1}) begin errors++; $display("FAIL areset_push: valid=%b id=%0d conflict=%b required 1 200 1", evt_valid, evt_id, conflict); end
  endtask

  initial begin
    test_reset();
    test_rdc_unit();
    test_fifo_full();
    test_markers();
    test_set_wrap();
    test_push_pop();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
